pc_ras: RTL and testbench

//   Parametrised program counter with an integrated hardware return-address stack (RAS).

---
 rtl/pc_ras_pkg.sv | 29 ++
 rtl/pc_ras_ras_stack.sv | 74 +++++++
 rtl/pc_ras.sv | 63 ++++++
 tb/tb_pc_ras.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/pc_ras_pkg.sv
// rtl/pc_ras_pkg.sv - shared definitions for the program counter with return-address stack
package pc_ras_pkg;

   localparam int WRAP_DROP      = 0;
   localparam int WRAP_OVERWRITE = 1;

   typedef enum logic [2:0] {
      OP_RESET,
      OP_JMP,
      OP_CALL,
      OP_RET,
      OP_LOAD,
      OP_INC,
      OP_HOLD
   } pc_op_e;

   // First match wins; call and ret together form a tail jump.
   function automatic pc_op_e pc_decode(input logic reset, input logic call, input logic ret,
                                        input logic load, input logic inc);
      if (!reset)           return OP_RESET;
      else if (call && ret) return OP_JMP;
      else if (call)        return OP_CALL;
      else if (ret)         return OP_RET;
      else if (load)        return OP_LOAD;
      else if (inc)         return OP_INC;
      else                  return OP_HOLD;
   endfunction

endpackage

// File: rtl/pc_ras_ras_stack.sv
// rtl/pc_ras_ras_stack.sv - circular return-address stack with sticky overflow/underflow
module ras_stack
   import pc_ras_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8,
   parameter int WRAP  = WRAP_DROP
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         push,
   input  logic                         pop,
   input  logic [WIDTH-1:0]             din,
   output logic [WIDTH-1:0]             dout,
   output logic [$clog2(DEPTH+1)-1:0]   depth,
   output logic                         empty,
   output logic                         full,
   output logic                         ovf,
   output logic                         unf
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int DW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    head;
   logic [PW-1:0]    head_nxt;
   logic [PW-1:0]    head_prv;
   logic [DW-1:0]    count;
   logic             wr_en;

   // head points at the next free slot; the newest entry sits just below it
   assign head_nxt = (head == PW'(DEPTH-1)) ? '0 : head + 1'b1;
   assign head_prv = (head == '0) ? PW'(DEPTH-1) : head - 1'b1;

   assign empty = (count == '0);
   assign full  = (count == DW'(DEPTH));
   assign depth = count;
   assign dout  = empty ? '0 : mem[head_prv];

   // When full in overwrite mode head already sits on the oldest entry
   assign wr_en = reset && push && (!full || (WRAP == WRAP_OVERWRITE));

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[head] <= din;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         head  <= '0;
         count <= '0;
         ovf   <= 1'b0;
         unf   <= 1'b0;
      end else if (push) begin
         if (!full) begin
            head  <= head_nxt;
            count <= count + 1'b1;
         end else if (WRAP == WRAP_OVERWRITE) begin
            head  <= head_nxt;
         end else begin
            ovf   <= 1'b1;
         end
      end else if (pop) begin
         if (!empty) begin
            head  <= head_prv;
            count <= count - 1'b1;
         end else begin
            unf   <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/pc_ras.sv
// rtl/pc_ras.sv - program counter with integrated call/return address stack
module pc_ras
   import pc_ras_pkg::*;
#(
   parameter int WIDTH        = 16,
   parameter int DEPTH        = 8,
   parameter int STEP         = 1,
   parameter int RESET_VECTOR = 0,
   parameter int WRAP         = WRAP_DROP
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [WIDTH-1:0]             in,
   input  logic                         load,
   input  logic                         inc,
   input  logic                         call,
   input  logic                         ret,
   output logic [WIDTH-1:0]             out,
   output logic [WIDTH-1:0]             top,
   output logic [$clog2(DEPTH+1)-1:0]   depth,
   output logic                         empty,
   output logic                         full,
   output logic                         overflow,
   output logic                         underflow
);

   pc_op_e           op;
   logic [WIDTH-1:0] next_seq;

   assign op       = pc_decode(reset, call, ret, load, inc);
   assign next_seq = out + WIDTH'(STEP);

   ras_stack #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .WRAP  (WRAP)
   ) u_stack (
      .clk   (clk),
      .reset (reset),
      .push  (op == OP_CALL),
      .pop   (op == OP_RET),
      .din   (next_seq),
      .dout  (top),
      .depth (depth),
      .empty (empty),
      .full  (full),
      .ovf   (overflow),
      .unf   (underflow)
   );

   always_ff @(posedge clk) begin
      case (op)
         OP_RESET: out <= WIDTH'(RESET_VECTOR);
         OP_JMP:   out <= in;
         OP_CALL:  out <= in;
         OP_RET:   if (!empty) out <= top;
         OP_LOAD:  out <= in;
         OP_INC:   out <= next_seq;
         default:  out <= out;
      endcase
   end

endmodule

// File: tb/tb_pc_ras.sv
// tb/tb_pc_ras.sv - self-checking bench for pc_ras in drop and overwrite modes
module tb_pc_ras;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] din = '0;
   logic        load = 1'b0, inc = 1'b0, call = 1'b0, ret = 1'b0;

   logic [15:0] out0, top0, out1, top1;
   logic [2:0]  dep0, dep1;
   logic        emp0, ful0, ovf0, unf0, emp1, ful1, ovf1, unf1;

   int tests = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pc_ras #(.WIDTH(16), .DEPTH(4), .STEP(1), .RESET_VECTOR(0), .WRAP(0)) dut0 (
      .clk(clk), .reset(rst), .in(din), .load(load), .inc(inc), .call(call), .ret(ret),
      .out(out0), .top(top0), .depth(dep0), .empty(emp0), .full(ful0),
      .overflow(ovf0), .underflow(unf0));

   pc_ras #(.WIDTH(16), .DEPTH(4), .STEP(1), .RESET_VECTOR(0), .WRAP(1)) dut1 (
      .clk(clk), .reset(rst), .in(din), .load(load), .inc(inc), .call(call), .ret(ret),
      .out(out1), .top(top1), .depth(dep1), .empty(emp1), .full(ful1),
      .overflow(ovf1), .underflow(unf1));

   // Reference model: list of return addresses, index 0 oldest
   logic [15:0] ms [2][4];
   int          mcnt [2];
   logic [15:0] mout [2];
   bit          movf [2];
   bit          munf [2];

   task automatic model_step(input int w, input bit rs, input logic [15:0] i,
                             input bit ld, input bit ic, input bit cl, input bit rt);
      logic [15:0] ra;
      if (!rs) begin
         mout[w] = 16'd0; mcnt[w] = 0; movf[w] = 0; munf[w] = 0;
      end else if (cl && rt) begin
         mout[w] = i;
      end else if (cl) begin
         ra = mout[w] + 16'd1;
         if (mcnt[w] < 4) begin
            ms[w][mcnt[w]] = ra;
            mcnt[w] = mcnt[w] + 1;
         end else if (w == 0) begin
            movf[w] = 1;
         end else begin
            for (int k = 0; k < 3; k++) ms[w][k] = ms[w][k+1];
            ms[w][3] = ra;
         end
         mout[w] = i;
      end else if (rt) begin
         if (mcnt[w] == 0) munf[w] = 1;
         else begin
            mcnt[w] = mcnt[w] - 1;
            mout[w] = ms[w][mcnt[w]];
         end
      end else if (ld) begin
         mout[w] = i;
      end else if (ic) begin
         mout[w] = mout[w] + 16'd1;
      end
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
      end
   endtask

   task automatic step(input bit rs, input logic [15:0] i, input bit ld, input bit ic,
                       input bit cl, input bit rt);
      rst = rs; din = i; load = ld; inc = ic; call = cl; ret = rt;
      @(posedge clk);
      model_step(0, rs, i, ld, ic, cl, rt);
      model_step(1, rs, i, ld, ic, cl, rt);
      #1;
   endtask

   typedef struct {
      bit          rs;
      logic [15:0] i;
      bit          ld, ic, cl, rt;
      logic [15:0] eo, et;
      int          ed;
      bit          ee, eovf, eunf;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(bit rs, int i, bit ld, bit ic, bit cl, bit rt,
                               int eo, int et, int ed, bit ee, bit eovf, bit eunf);
      vec_t v;
      v.rs = rs; v.i = 16'(i); v.ld = ld; v.ic = ic; v.cl = cl; v.rt = rt;
      v.eo = 16'(eo); v.et = 16'(et); v.ed = ed; v.ee = ee; v.eovf = eovf; v.eunf = eunf;
      return v;
   endfunction

   function automatic int sx(logic [15:0] v);
      return int'($signed(v));
   endfunction

   initial begin
      // reset dominates, then counting
      tbl.push_back(mk(0, 1234, 1, 1, 1, 0,   0,   0, 0, 1, 0, 0));
      tbl.push_back(mk(1, 0,    0, 1, 0, 0,   1,   0, 0, 1, 0, 0));
      tbl.push_back(mk(1, 0,    0, 1, 0, 0,   2,   0, 0, 1, 0, 0));
      tbl.push_back(mk(1, 0,    0, 1, 0, 0,   3,   0, 0, 1, 0, 0));
      // load, wrap, load beats inc
      tbl.push_back(mk(1, -32123, 1, 0, 0, 0, -32123, 0, 0, 1, 0, 0));
      tbl.push_back(mk(1, -1,   1, 0, 0, 0,  -1,   0, 0, 1, 0, 0));
      tbl.push_back(mk(1, 0,    0, 1, 0, 0,   0,   0, 0, 1, 0, 0));
      tbl.push_back(mk(1, 12345, 1, 1, 0, 0, 12345, 0, 0, 1, 0, 0));
      // nested call/ret
      tbl.push_back(mk(1, 100,  1, 0, 0, 0, 100,   0, 0, 1, 0, 0));
      tbl.push_back(mk(1, 200,  0, 0, 1, 0, 200, 101, 1, 0, 0, 0));
      tbl.push_back(mk(1, 300,  0, 0, 1, 0, 300, 201, 2, 0, 0, 0));
      tbl.push_back(mk(1, 0,    0, 0, 0, 1, 201, 101, 1, 0, 0, 0));
      tbl.push_back(mk(1, 0,    0, 0, 0, 1, 101,   0, 0, 1, 0, 0));
      // tail jump and reset during call
      tbl.push_back(mk(1, 10,   1, 0, 0, 0,  10,   0, 0, 1, 0, 0));
      tbl.push_back(mk(1, 20,   0, 0, 1, 0,  20,  11, 1, 0, 0, 0));
      tbl.push_back(mk(1, 30,   0, 0, 1, 0,  30,  21, 2, 0, 0, 0));
      tbl.push_back(mk(1, 500,  1, 1, 1, 1, 500,  21, 2, 0, 0, 0));
      tbl.push_back(mk(0, 7,    0, 0, 1, 0,   0,   0, 0, 1, 0, 0));
      // underflow is sticky until reset
      tbl.push_back(mk(1, 77,   1, 0, 0, 0,  77,   0, 0, 1, 0, 0));
      tbl.push_back(mk(1, 0,    0, 0, 0, 1,  77,   0, 0, 1, 0, 1));
      for (int k = 1; k <= 5; k++)
         tbl.push_back(mk(1, 0, 0, 1, 0, 0, 77 + k, 0, 0, 1, 0, 1));
      tbl.push_back(mk(0, 0,    0, 0, 0, 0,   0,   0, 0, 1, 0, 0));

      foreach (tbl[n]) begin
         step(tbl[n].rs, tbl[n].i, tbl[n].ld, tbl[n].ic, tbl[n].cl, tbl[n].rt);
         chk($sformatf("tbl%0d.out", n),   sx(out0),  sx(tbl[n].eo));
         chk($sformatf("tbl%0d.top", n),   sx(top0),  sx(tbl[n].et));
         chk($sformatf("tbl%0d.depth", n), int'(dep0), tbl[n].ed);
         chk($sformatf("tbl%0d.empty", n), int'(emp0), int'(tbl[n].ee));
         chk($sformatf("tbl%0d.ovf", n),   int'(ovf0), int'(tbl[n].eovf));
         chk($sformatf("tbl%0d.unf", n),   int'(unf0), int'(tbl[n].eunf));
         chk($sformatf("tbl%0d.out_w1", n), sx(out1), sx(tbl[n].eo));
         chk($sformatf("tbl%0d.unf_w1", n), int'(unf1), int'(tbl[n].eunf));
      end

      // full stack: drop versus overwrite
      step(0, 0, 0, 0, 0, 0);
      step(1, 10, 0, 0, 1, 0);
      step(1, 20, 0, 0, 1, 0);
      step(1, 30, 0, 0, 1, 0);
      step(1, 40, 0, 0, 1, 0);
      chk("full_w0", int'(ful0), 1);
      chk("full_w1", int'(ful1), 1);
      chk("top4_w0", int'(top0), 31);
      step(1, 999, 0, 0, 1, 0);
      chk("ovcall_out_w0", int'(out0), 999);
      chk("ovcall_dep_w0", int'(dep0), 4);
      chk("ovcall_top_w0", int'(top0), 31);
      chk("ovcall_ovf_w0", int'(ovf0), 1);
      chk("ovcall_out_w1", int'(out1), 999);
      chk("ovcall_dep_w1", int'(dep1), 4);
      chk("ovcall_top_w1", int'(top1), 41);
      chk("ovcall_ovf_w1", int'(ovf1), 0);
      begin
         int exp0 [4] = '{31, 21, 11, 1};
         int exp1 [4] = '{41, 31, 21, 11};
         for (int k = 0; k < 4; k++) begin
            step(1, 0, 0, 0, 0, 1);
            chk($sformatf("pop%0d_w0", k), int'(out0), exp0[k]);
            chk($sformatf("pop%0d_w1", k), int'(out1), exp1[k]);
         end
      end
      step(1, 0, 0, 0, 0, 1);
      chk("unf_w0", int'(unf0), 1);
      chk("unf_w1", int'(unf1), 1);
      chk("unf_hold_w0", int'(out0), 1);
      chk("unf_hold_w1", int'(out1), 11);

      // randomized run against the reference model
      step(0, 0, 0, 0, 0, 0);
      for (int n = 0; n < 3000; n++) begin
         bit rs, ld, ic, cl, rt;
         rs = ($urandom_range(0, 99) != 0);
         cl = ($urandom_range(0, 99) < 25);
         rt = ($urandom_range(0, 99) < 25);
         ld = ($urandom_range(0, 99) < 20);
         ic = ($urandom_range(0, 99) < 40);
         step(rs, 16'($urandom), ld, ic, cl, rt);
         chk("rnd.out_w0", int'(out0), int'(mout[0]));
         chk("rnd.out_w1", int'(out1), int'(mout[1]));
         chk("rnd.dep_w0", int'(dep0), mcnt[0]);
         chk("rnd.dep_w1", int'(dep1), mcnt[1]);
         chk("rnd.top_w0", int'(top0), (mcnt[0] > 0) ? int'(ms[0][mcnt[0]-1]) : 0);
         chk("rnd.top_w1", int'(top1), (mcnt[1] > 0) ? int'(ms[1][mcnt[1]-1]) : 0);
         chk("rnd.full_w0", int'(ful0), int'(mcnt[0] == 4));
         chk("rnd.empty_w1", int'(emp1), int'(mcnt[1] == 0));
         chk("rnd.ovf_w0", int'(ovf0), int'(movf[0]));
         chk("rnd.ovf_w1", int'(ovf1), int'(movf[1]));
         chk("rnd.unf_w0", int'(unf0), int'(munf[0]));
         chk("rnd.unf_w1", int'(unf1), int'(munf[1]));
      end

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
